// File: rtl/ivwb_buffer_if.sv
// ALU-result / register-file / ROB signal bundle for the vector integer writeback buffer.
// The slave side is the buffer; the master side drives ALU results and the RF ready.
interface ivwb_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   result_i;
  logic [4:0]    rob_i;
  logic [5:0]    dest_i;
  logic          wb_valid_i;
  logic          valid_i;
  logic          flush_i;
  logic          issue_stall_o;
  logic          rf_wr_en_o;
  logic [5:0]    rf_wr_addr_o;
  logic [31:0]   rf_wr_data_o;
  logic          rf_wr_ready_i;
  logic          rob_done_valid_o;
  logic [4:0]    rob_done_id_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;

  modport slave (
    input  result_i, rob_i, dest_i, wb_valid_i, valid_i, flush_i, rf_wr_ready_i,
    output issue_stall_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o,
           rob_done_valid_o, rob_done_id_o, count_o, overflow_o
  );

  modport master (
    output result_i, rob_i, dest_i, wb_valid_i, valid_i, flush_i, rf_wr_ready_i,
    input  issue_stall_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o,
           rob_done_valid_o, rob_done_id_o, count_o, overflow_o
  );
endinterface

// File: rtl/ivwb_buffer.sv
// Writeback buffer: queues ALU results with no backpressure and drains them into the
// shared register-file write port, strobing ROB completion for every entry.
module ivwb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic          core_clock_i,
  input  logic          core_reset_i,
  ivwb_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rob;
    logic [5:0]  dest;
    logic        wb;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          head_v, pop, push_req, push, drop;

  assign head     = mem[rd_ptr];
  assign head_v   = (count != '0) & ~bus.flush_i;
  // Entries with no RF write complete without waiting on the register file.
  assign pop      = head_v & (~head.wb | bus.rf_wr_ready_i);
  assign push_req = bus.valid_i & ~bus.flush_i;
  assign push     = push_req & ((count != CW'(DEPTH)) | pop);
  assign drop     = push_req & ~push;

  always_ff @(posedge core_clock_i) begin
    if (push) mem[wr_ptr] <= '{result: bus.result_i, rob: bus.rob_i,
                               dest: bus.dest_i, wb: bus.wb_valid_i};
  end

  always_ff @(posedge core_clock_i or negedge core_reset_i) begin
    if (!core_reset_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (bus.flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  // Two free slots: one for the op already in the ALU, one for the op issuing now.
  assign bus.issue_stall_o    = count >= CW'(DEPTH - 2);
  assign bus.rf_wr_en_o       = head_v & head.wb;
  assign bus.rf_wr_addr_o     = bus.rf_wr_en_o ? head.dest   : '0;
  assign bus.rf_wr_data_o     = bus.rf_wr_en_o ? head.result : '0;
  assign bus.rob_done_valid_o = pop;
  assign bus.rob_done_id_o    = pop ? head.rob : '0;
  assign bus.count_o          = count;
  assign bus.overflow_o       = overflow;
endmodule

// File: tb/tb_ivwb_buffer.sv
// Scoreboard bench for ivwb_buffer: the driver queues expected completions, the monitor
// pops and compares on every ROB completion strobe.
module tb_ivwb_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ivwb_buffer_if #(.DEPTH(DEPTH)) bus ();
  ivwb_buffer #(.DEPTH(DEPTH)) dut (.core_clock_i(clk), .core_reset_i(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] d;
    logic [4:0]  r;
    logic [5:0]  a;
    logic        w;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [31:0] d, logic [4:0] r, logic [5:0] a, logic w, bit accept);
    bus.valid_i    = 1'b1;
    bus.result_i   = d;
    bus.rob_i      = r;
    bus.dest_i     = a;
    bus.wb_valid_i = w;
    if (accept) q.push_back('{d: d, r: r, a: a, w: w});
  endtask

  task automatic idle();
    bus.valid_i    = 1'b0;
    bus.result_i   = '0;
    bus.rob_i      = '0;
    bus.dest_i     = '0;
    bus.wb_valid_i = 1'b0;
  endtask

  // Monitor: every completion must match the oldest outstanding accepted result.
  always @(negedge clk) begin
    if (rst_n && bus.rob_done_valid_o) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got id %0h expected none", bus.rob_done_id_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_id", 32'(bus.rob_done_id_o), 32'(e.r));
        chk("wr_en",   32'(bus.rf_wr_en_o),    32'(e.w));
        chk("wr_addr", 32'(bus.rf_wr_addr_o),  e.w ? 32'(e.a) : 32'd0);
        chk("wr_data", bus.rf_wr_data_o,       e.w ? e.d : 32'd0);
      end
    end
  end

  initial begin
    bit   pend;
    logic w;
    int   rob_n;

    // Reset with random inputs: every output must be zero.
    bus.valid_i       = 1'b1;
    bus.result_i      = $urandom;
    bus.rob_i         = 5'($urandom);
    bus.dest_i        = 6'($urandom);
    bus.wb_valid_i    = 1'b1;
    bus.flush_i       = 1'($urandom);
    bus.rf_wr_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_count",  32'(bus.count_o), 0);
    chk("rst_ovf",    32'(bus.overflow_o), 0);
    chk("rst_stall",  32'(bus.issue_stall_o), 0);
    chk("rst_wr_en",  32'(bus.rf_wr_en_o), 0);
    chk("rst_addr",   32'(bus.rf_wr_addr_o), 0);
    chk("rst_data",   bus.rf_wr_data_o, 0);
    chk("rst_done",   32'(bus.rob_done_valid_o), 0);
    chk("rst_id",     32'(bus.rob_done_id_o), 0);
    idle();
    bus.flush_i = 1'b0;
    rst_n = 1'b1;

    // Single entry with ready held high: presented the next cycle, then pops.
    tick();
    push(32'hDEADBEEF, 5'd3, 6'd12, 1'b1, 1);
    @(negedge clk);
    chk("t1_count0", 32'(bus.count_o), 0);
    chk("t1_nobypass", 32'(bus.rf_wr_en_o), 0);
    tick(); idle();
    @(negedge clk);
    chk("t1_count1", 32'(bus.count_o), 1);
    chk("t1_wr_en", 32'(bus.rf_wr_en_o), 1);
    tick();
    @(negedge clk);
    chk("t1_count_end", 32'(bus.count_o), 0);

    // Fill with ready low, overflow on the fifth push, then drain in order.
    bus.rf_wr_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      push(32'h1000 + i, 5'(10 + i), 6'(20 + i), 1'b1, 1);
      @(negedge clk);
      chk("t2_count", 32'(bus.count_o), i);
      chk("t2_stall", 32'(bus.issue_stall_o), (i >= 2) ? 1 : 0);
    end
    tick();
    push(32'h1004, 5'd14, 6'd24, 1'b1, 0);
    @(negedge clk);
    chk("t2_full", 32'(bus.count_o), 4);
    chk("t2_held", 32'(bus.rob_done_valid_o), 0);
    tick(); idle();
    @(negedge clk);
    chk("t2_count_ovf", 32'(bus.count_o), 4);
    chk("t2_ovf", 32'(bus.overflow_o), 1);
    bus.rf_wr_ready_i = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("t2_drained", 32'(bus.count_o), 0);
    chk("t2_ovf_sticky", 32'(bus.overflow_o), 1);

    // Reset mid-operation empties the FIFO and clears overflow.
    bus.rf_wr_ready_i = 1'b0;
    tick(); push(32'hA0, 5'd1, 6'd1, 1'b1, 1);
    tick(); push(32'hA1, 5'd2, 6'd2, 1'b1, 1);
    tick(); idle();
    @(negedge clk);
    chk("mr_count", 32'(bus.count_o), 2);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("mr_count0", 32'(bus.count_o), 0);
    chk("mr_ovf0", 32'(bus.overflow_o), 0);
    chk("mr_wr_en", 32'(bus.rf_wr_en_o), 0);
    tick();
    rst_n = 1'b1;

    // wb = 0 entry completes without waiting on the register file.
    tick();
    push(32'h55, 5'd7, 6'd0, 1'b0, 1);
    tick(); idle();
    @(negedge clk);
    chk("t3_wr_en", 32'(bus.rf_wr_en_o), 0);
    chk("t3_done", 32'(bus.rob_done_valid_o), 1);
    tick();
    @(negedge clk);
    chk("t3_count", 32'(bus.count_o), 0);

    // Full FIFO with simultaneous push and pop: count stays at DEPTH, pointers wrap.
    for (int i = 0; i < 4; i++) begin
      tick();
      push(32'h2000 + i, 5'(i), 6'(30 + i), 1'b1, 1);
    end
    for (int i = 4; i < 7; i++) begin
      tick();
      push(32'h2000 + i, 5'(i), 6'(30 + i), 1'b1, 1);
      bus.rf_wr_ready_i = 1'b1;
      @(negedge clk);
      chk("t4_count", 32'(bus.count_o), 4);
      chk("t4_ovf", 32'(bus.overflow_o), 0);
    end
    tick(); idle();
    @(negedge clk);
    chk("t4_count_last", 32'(bus.count_o), 4);
    repeat (4) tick();
    @(negedge clk);
    chk("t4_drained", 32'(bus.count_o), 0);

    // Flush with an incoming result: nothing transfers, everything is discarded.
    bus.rf_wr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      push(32'h3000 + i, 5'(20 + i), 6'(40 + i), 1'b1, 1);
    end
    tick();
    push(32'h3099, 5'd25, 6'd50, 1'b1, 0);
    bus.flush_i = 1'b1;
    bus.rf_wr_ready_i = 1'b1;
    q.delete();
    @(negedge clk);
    chk("t5_wr_en", 32'(bus.rf_wr_en_o), 0);
    chk("t5_done", 32'(bus.rob_done_valid_o), 0);
    chk("t5_count_pre", 32'(bus.count_o), 3);
    tick(); idle();
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("t5_count", 32'(bus.count_o), 0);
    chk("t5_ovf", 32'(bus.overflow_o), 0);
    tick();
    push(32'hCAFE0001, 5'd9, 6'd9, 1'b1, 1);
    tick(); idle();
    tick();
    @(negedge clk);
    chk("t5_after", 32'(bus.count_o), 0);

    // Random issue honouring issue_stall_o through a one-cycle ALU, random ready.
    pend = 1'b0;
    rob_n = 0;
    for (int n = 0; n < 10000; n++) begin
      tick();
      bus.rf_wr_ready_i = 1'($urandom_range(0, 1));
      if (pend) begin
        w = 1'($urandom_range(0, 1));
        push($urandom, 5'(rob_n), w ? 6'($urandom_range(1, 63)) : 6'd0, w, 1);
        rob_n++;
      end else begin
        idle();
      end
      pend = !bus.issue_stall_o && ($urandom_range(0, 1) == 1);
    end
    tick();
    if (pend) push($urandom, 5'(rob_n), 6'd5, 1'b1, 1);
    else idle();
    bus.rf_wr_ready_i = 1'b1;
    tick(); idle();
    repeat (8) tick();
    @(negedge clk);
    chk("rnd_ovf", 32'(bus.overflow_o), 0);
    chk("rnd_count", 32'(bus.count_o), 0);
    chk("rnd_sb_empty", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ivwb_buffer.md
# ivwb_buffer

Writeback buffer on the receiving end of the vector integer ALU result interface. It accepts one ALU result per cycle with no backpressure into the ALU and queues it in a small FIFO. It drains entries into the shared register-file write port, which has a ready handshake, and signals ROB completion for every entry. It throttles the issue stage so that results still in flight in the ALU always have a free slot.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥ 4.

Ports:
- core_clock_i  in  1  single clock; all state on its rising edge.
- core_reset_i  in  1  asynchronous, active-low reset.
- result_i  in  32  ALU result data.
- rob_i  in  5  ROB index of the result.
- dest_i  in  6  physical destination register.
- wb_valid_i  in  1  result must be written to the register file (dest_i ≠ 0).
- valid_i  in  1  result present this cycle.
- flush_i  in  1  pipeline flush; discards all queued and incoming results.
- issue_stall_o  out  1  issue stage must not issue a new ALU op this cycle.
- rf_wr_en_o  out  1  register-file write request.
- rf_wr_addr_o  out  6  register-file write address.
- rf_wr_data_o  out  32  register-file write data.
- rf_wr_ready_i  in  1  register-file port accepts the write this cycle.
- rob_done_valid_o  out  1  ROB completion strobe.
- rob_done_id_o  out  5  ROB index completed.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky error: a result was dropped because the FIFO was full.

## Operation
- Each entry holds {result, rob, dest, wb}. Write and read pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is held in a separate counter.
- Push: valid_i & !flush_i.
  - Accepted when count < DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the result is dropped and overflow_o is set. overflow_o stays set until reset.
- Head presentation, with head_v = count ≠ 0 & !flush_i:
  - rf_wr_en_o = head_v & head.wb.
  - rf_wr_addr_o and rf_wr_data_o come from the head entry, forced to 0 when rf_wr_en_o = 0.
- Pop:
  - head_v & (!head.wb | rf_wr_ready_i).
  - An entry with wb = 0 pops without waiting on the register file.
- rob_done_valid_o = pop. rob_done_id_o = head.rob when pop, else 0.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Flush:
  - Next cycle count = 0 and both pointers = 0.
  - No pop or push occurs in the flush cycle.
  - overflow_o is unaffected.
- issue_stall_o = (DEPTH − count) ≤ 2, driven combinationally from the registered count. This guarantees a free slot for one op already in the ALU plus one being issued.
- Storage arrays are not reset. The counter, pointers and overflow flag are reset.

## Timing
- Reset values while core_reset_i = 0: count_o = 0, overflow_o = 0, issue_stall_o = 0, rf_wr_en_o = 0, rf_wr_addr_o = 0, rf_wr_data_o = 0, rob_done_valid_o = 0, rob_done_id_o = 0.
- Reset asserted mid-operation empties the FIFO asynchronously.
- Latency: a result with valid_i high in cycle t is presented at the head no earlier than cycle t+1. There is no same-cycle bypass.
- Drain rate is one entry per cycle when rf_wr_ready_i is held high or wb = 0.
- Register-file handshake: rf_wr_en_o and the head fields stay stable until rf_wr_ready_i is sampled high. The transfer completes on that edge.
- The ROB completion strobe is one cycle wide per entry and coincides with the register-file transfer cycle.
- Full (count = DEPTH): a push is accepted only with a simultaneous pop. issue_stall_o is high whenever count ≥ DEPTH−2.
- Empty: all head outputs are 0, and rf_wr_ready_i is ignored.

## Test plan
- Reset with core_reset_i = 0 and random inputs → all outputs 0. After release, push {result 0xDEADBEEF, rob 3, dest 12, wb 1} with ready held 1 → next cycle rf_wr_en_o = 1, addr 12, data 0xDEADBEEF, rob_done_id_o = 3, count returns to 0.
- Push four wb = 1 entries back-to-back with ready = 0 → count 4. issue_stall_o rises when count reaches 2. A fifth push with no pop → overflow_o = 1, count stays 4. Then ready = 1 → four writes in FIFO order over 4 cycles.
- Push entry with wb = 0, rob 7 and ready = 0 → rob_done_valid_o = 1, id 7, rf_wr_en_o = 0, entry pops in one cycle.
- Full FIFO, ready = 1, push on the same cycle → count stays 4, no overflow, pointers wrap past DEPTH−1 to 0.
- Three queued entries, then flush_i = 1 together with valid_i = 1 → that cycle rf_wr_en_o = 0 and rob_done_valid_o = 0. Next cycle count = 0, the incoming result is discarded, overflow_o unchanged.
- Random issue respecting issue_stall_o, with a 1-cycle ALU model and random ready, over 10k cycles → overflow_o never set, and register-file write and ROB completion order matches push order.
